aes_out_collector: RTL and testbench

Downstream stage of the 8-bit serial AES core. It watches the core's byte stream and its sticky data-valid flag, and captures the 16 ciphertext bytes that follow valid assertion. It packs them into a 128-bit block and hands the block to a consumer (bus bridge, UART framer) over a valid/ready handshake. It also flags overruns and can optionally self-check the block against a known-answer value.

---
 rtl/aes_out_pkg.sv | 16 +
 rtl/aes_out_shreg.sv | 23 ++
 rtl/aes_out_collector.sv | 123 ++++++++++++
 tb/tb_aes_out_collector.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_out_pkg.sv
// aes_out_pkg: shared types and constants for the AES output collector.
// Holds the collector FSM encoding, the AES block size in bytes and the
// FIPS-197 Appendix B ciphertext used as the default known-answer value.
package aes_out_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int AES_BLOCK_BYTES = 16;

  localparam logic [127:0] FIPS197_CT = 128'h3925841d02dc09fbdc118597196a0b32;

endpackage

// File: rtl/aes_out_shreg.sv
// aes_out_shreg: DW-wide, NBYTES-deep byte shift register with load enable.
// Ports: clk, rst (sync, active-high), en (shift one byte in), din (new byte,
// enters the LSBs), q (full register, oldest byte in the MSBs).
module aes_out_shreg #(
  parameter int NBYTES = 16,
  parameter int DW     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DW-1:0]        din,
  output logic [NBYTES*DW-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= {q[NBYTES*DW-DW-1:0], din};
    end
  end

endmodule

// File: rtl/aes_out_collector.sv
// aes_out_collector: captures the NBYTES bytes that follow a rising edge of the
// AES core's sticky data-valid flag and offers them as one block over valid/ready.
// Ports: clk, rst (sync, active-high); din/din_vld from the core; blk_out,
// blk_valid, blk_ready to the consumer; busy, overrun (sticky), kat_pass/kat_fail.
// Optional known-answer check enabled by defining AES_OUT_KAT_CHECK_EN;
// without it kat_pass and kat_fail are tied low and no comparator exists.
module aes_out_collector
  import aes_out_pkg::*;
#(
  parameter int NBYTES = AES_BLOCK_BYTES,
  parameter int DW     = 8
`ifdef AES_OUT_KAT_CHECK_EN
  ,
  parameter logic [NBYTES*DW-1:0] KAT_VALUE = (NBYTES*DW)'(FIPS197_CT)
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        din,
  input  logic                 din_vld,
  output logic [NBYTES*DW-1:0] blk_out,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic                 busy,
  output logic                 overrun,
  output logic                 kat_pass,
  output logic                 kat_fail
);

  localparam int CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          vld_q;
  logic          start;
  logic          shift_en;
  logic          last_byte;

  // din_vld is sticky, so only its rising edge marks a new block.
  assign start     = din_vld & ~vld_q;
  assign last_byte = (state == CAPT) && (cnt == LAST);
  // The core cannot be stalled: once in CAPT every cycle carries a byte.
  assign shift_en  = ((state == IDLE) && start) || (state == CAPT);

  aes_out_shreg #(
    .NBYTES (NBYTES),
    .DW     (DW)
  ) u_shreg (
    .clk (clk),
    .rst (rst),
    .en  (shift_en),
    .din (din),
    .q   (blk_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      vld_q     <= 1'b0;
      blk_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      vld_q <= din_vld;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= CW'(1);
            busy  <= 1'b1;
            state <= CAPT;
          end
        end
        CAPT: begin
          // A new edge mid-capture cannot be serviced; just flag it.
          if (start) overrun <= 1'b1;
          if (cnt == LAST) begin
            cnt       <= '0;
            busy      <= 1'b0;
            blk_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          // The new block's data is dropped even if the held one leaves now.
          if (start) overrun <= 1'b1;
          if (blk_ready) begin
            blk_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef AES_OUT_KAT_CHECK_EN
  logic [NBYTES*DW-1:0] blk_next;

  // Compare the block as it will stand after the final shift, so the result
  // appears together with blk_valid.
  assign blk_next = {blk_out[NBYTES*DW-DW-1:0], din};

  always_ff @(posedge clk) begin
    if (rst) begin
      kat_pass <= 1'b0;
      kat_fail <= 1'b0;
    end else if (last_byte) begin
      kat_pass <= (blk_next == KAT_VALUE);
      kat_fail <= (blk_next != KAT_VALUE);
    end
  end
`else
  assign kat_pass = 1'b0;
  assign kat_fail = 1'b0;
`endif

endmodule

// File: tb/tb_aes_out_collector.sv
module tb_aes_out_collector;

  localparam logic [127:0] KAT = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   din;
  logic         din_vld;
  logic [127:0] blk_out;
  logic         blk_valid;
  logic         blk_ready;
  logic         busy;
  logic         overrun;
  logic         kat_pass;
  logic         kat_fail;

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [7:0]   bytes_q[$];
  logic [127:0] exp_blk;
  logic [127:0] kat_src;
  logic         ovr_exp;

  always #5 clk = ~clk;

  aes_out_collector dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_vld   (din_vld),
    .blk_out   (blk_out),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .busy      (busy),
    .overrun   (overrun),
    .kat_pass  (kat_pass),
    .kat_fail  (kat_fail)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the block is the captured bytes concatenated, first byte on top.
  function automatic logic [127:0] pack_bytes();
    logic [127:0] r;
    r = '0;
    foreach (bytes_q[i]) r = (r << 8) | 128'(bytes_q[i]);
    return r;
  endfunction

  function automatic logic exp_pass(input logic [127:0] b);
`ifdef AES_OUT_KAT_CHECK_EN
    return (b == KAT);
`else
    return 1'b0 & b[0];
`endif
  endfunction

  function automatic logic exp_failk(input logic [127:0] b);
`ifdef AES_OUT_KAT_CHECK_EN
    return (b != KAT);
`else
    return 1'b0 & b[0];
`endif
  endfunction

  task automatic fill_const(input logic [127:0] b);
    bytes_q.delete();
    for (int i = 0; i < 16; i++) bytes_q.push_back(b[127-8*i -: 8]);
  endtask

  task automatic fill_rand();
    bytes_q.delete();
    for (int i = 0; i < 16; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Drops din_vld for a cycle, raises it with byte 0 and streams 16 bytes.
  // glitch_at > 0 pulses din_vld low at that byte to create an edge mid-capture.
  task automatic capture(input int glitch_at, input bit ready_early);
    din_vld = 1'b0;
    step();
    din_vld = 1'b1;
    din     = bytes_q[0];
    for (int i = 1; i < 16; i++) begin
      step();
      din = bytes_q[i];
      if (i == 1) chk("busy_in_capt", busy, 1'b1);
      if (glitch_at > 0 && i == glitch_at) din_vld = 1'b0;
      if (glitch_at > 0 && i == glitch_at + 1) din_vld = 1'b1;
    end
    if (ready_early) blk_ready = 1'b1;
    chk("valid_before_last", blk_valid, 1'b0);
    step();
    exp_blk = pack_bytes();
    if (glitch_at > 0) ovr_exp = 1'b1;
    chk("valid_at_16", blk_valid, 1'b1);
    chk("busy_done", busy, 1'b0);
    chk("blk_out", blk_out, exp_blk);
    chk("overrun", overrun, ovr_exp);
    chk("kat_pass", kat_pass, exp_pass(exp_blk));
    chk("kat_fail", kat_fail, exp_failk(exp_blk));
  endtask

  task automatic accept();
    blk_ready = 1'b1;
    step();
    chk("valid_dropped", blk_valid, 1'b0);
    chk("blk_kept_after_accept", blk_out, exp_blk);
    blk_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    din       = 8'h00;
    din_vld   = 1'b0;
    blk_ready = 1'b0;
    ovr_exp   = 1'b0;
    step();
    step();
    chk("rst_blk_out", blk_out, '0);
    chk("rst_blk_valid", blk_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_kat_pass", kat_pass, 1'b0);
    chk("rst_kat_fail", kat_fail, 1'b0);
    rst = 1'b0;
    step();

    // Known-answer block, consumer stalls 10 cycles.
    kat_src = KAT;
    fill_const(kat_src);
    capture(0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_stable", blk_out, exp_blk);
      chk("hold_valid", blk_valid, 1'b1);
    end
    accept();

    // din_vld stays high: no further capture.
    for (int i = 0; i < 20; i++) begin
      step();
      chk("no_recapture_busy", busy, 1'b0);
      chk("no_recapture_valid", blk_valid, 1'b0);
    end

    // New edge while a block is held.
    fill_rand();
    capture(0, 1'b0);
    din_vld = 1'b0;
    step();
    din_vld = 1'b1;
    din     = 8'ha5;
    step();
    ovr_exp = 1'b1;
    chk("overrun_hold", overrun, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_after_overrun", blk_out, exp_blk);
      chk("busy_after_overrun", busy, 1'b0);
    end
    accept();

    // Reset in the middle of a capture.
    din_vld = 1'b0;
    step();
    din_vld = 1'b1;
    for (int i = 0; i < 7; i++) begin
      din = 8'($urandom_range(0, 255));
      step();
    end
    rst     = 1'b1;
    din_vld = 1'b0;
    step();
    rst     = 1'b0;
    ovr_exp = 1'b0;
    chk("midrst_blk_out", blk_out, '0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_overrun", overrun, 1'b0);
    chk("midrst_valid", blk_valid, 1'b0);
    bytes_q.delete();
    for (int i = 0; i < 16; i++) bytes_q.push_back(8'(i));
    capture(0, 1'b0);
    chk("seq_block", blk_out, 128'h000102030405060708090a0b0c0d0e0f);
    accept();

    // All-ones block fails the known-answer check.
    fill_const({128{1'b1}});
    capture(0, 1'b1);
    accept();

    // Random blocks with random consumer delay; one edge inside a capture.
    for (int b = 0; b < 6; b++) begin
      int dly;
      fill_rand();
      dly = $urandom_range(0, 5);
      capture((b == 3) ? int'($urandom_range(1, 13)) : 0, dly == 0);
      for (int i = 0; i < dly; i++) begin
        step();
        chk("rand_hold_stable", blk_out, exp_blk);
      end
      accept();
      chk("rand_overrun", overrun, ovr_exp);
    end

    // Edge arriving in the same cycle the held block is accepted.
    fill_rand();
    capture(0, 1'b0);
    din_vld = 1'b0;
    step();
    din_vld   = 1'b1;
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    chk("same_cycle_valid", blk_valid, 1'b0);
    chk("same_cycle_overrun", overrun, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("same_cycle_no_capture", busy, 1'b0);
      chk("same_cycle_blk", blk_out, exp_blk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
